// File: rtl/adc_pkg.sv
// Shared types and constants for the SAR ADC conversion path.
// Used by the sequencer and its comparator model.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        SETTLE,
        CONVERT
    } sar_state_t;

    localparam int SAR_SETTLE_CYC = 2;
    localparam int ADC_IN_W       = 16;
    localparam int ADC_U_W        = 17;

endpackage

// File: rtl/sar_cmp_model.sv
// Behavioural SAR DAC/comparator: decides trial <= u_s for the held value.
// Stands in for the analog comparator interface in silicon.
module sar_cmp_model
    import adc_pkg::*;
#(
    parameter int RES_BITS = 12
) (
    input  logic [ADC_IN_W-1:0] i_hold_p,
    input  logic [ADC_IN_W-1:0] i_hold_n,
    input  logic [RES_BITS-1:0] i_trial,
    output logic                o_keep
);

    localparam int SHIFT = ADC_U_W - RES_BITS;

    logic [ADC_U_W-1:0] w_u;

    assign w_u = {1'b0, i_hold_p} - {1'b0, i_hold_n} + ADC_U_W'(17'h10000);

    // trial <= u >> SHIFT is the same as (trial << SHIFT) <= u for integers
    assign o_keep = {i_trial, {SHIFT{1'b0}}} <= w_u;

endmodule

// File: rtl/sar_controller.sv
// Successive-approximation sequencer: S/H track window, settle, MSB-first
// resolve and a valid/ready result register with overrun reporting.
module sar_controller
    import adc_pkg::*;
#(
    parameter int RES_BITS = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                start,
    input  logic                cont,
    input  logic [3:0]          track_cycles,
    output logic                sample_en,
    input  logic [ADC_IN_W-1:0] hold_p,
    input  logic [ADC_IN_W-1:0] hold_n,
    output logic [RES_BITS-1:0] result,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                busy,
    output logic                overrun
);

    localparam int BIT_W = $clog2(RES_BITS);

    sar_state_t          r_state;
    sar_state_t          w_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic [3:0]          w_track_len;
    logic [BIT_W-1:0]    r_bit;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic [RES_BITS-1:0] r_sar;
    logic [RES_BITS-1:0] w_sar_nxt;
    logic [RES_BITS-1:0] w_trial;
    logic                w_keep;
    logic                w_load;

    logic                r_sample_en;
    logic                r_busy;
    logic                r_valid;
    logic                r_overrun;
    logic [RES_BITS-1:0] r_result;

    assign w_track_len = (track_cycles == 4'd0) ? 4'd1 : track_cycles;
    assign w_trial     = r_sar | (RES_BITS'(1) << r_bit);

    sar_cmp_model #(
        .RES_BITS(RES_BITS)
    ) u_cmp (
        .i_hold_p(hold_p),
        .i_hold_n(hold_n),
        .i_trial (w_trial),
        .o_keep  (w_keep)
    );

    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_cnt;
        w_bit_nxt = r_bit;
        w_sar_nxt = r_sar;
        w_load    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start || cont) begin
                    w_nxt     = TRACK;
                    w_cnt_nxt = w_track_len - 4'd1;
                end
            end
            TRACK: begin
                if (r_cnt == 4'd0) begin
                    w_nxt     = SETTLE;
                    w_cnt_nxt = 4'(SAR_SETTLE_CYC - 1);
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            SETTLE: begin
                if (r_cnt == 4'd0) begin
                    w_nxt     = CONVERT;
                    w_bit_nxt = BIT_W'(RES_BITS - 1);
                    w_sar_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            CONVERT: begin
                w_sar_nxt = w_keep ? w_trial : r_sar;
                if (r_bit == '0) begin
                    w_load = 1'b1;
                    if (cont) begin
                        w_nxt     = TRACK;
                        w_cnt_nxt = w_track_len - 4'd1;
                    end else begin
                        w_nxt = IDLE;
                    end
                end else begin
                    w_bit_nxt = r_bit - BIT_W'(1);
                end
            end
            default: w_nxt = IDLE;
        endcase
        // Disable wins over everything except the held result
        if (!enable) begin
            w_nxt     = IDLE;
            w_sar_nxt = '0;
            w_load    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sar   <= '0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_sar   <= w_sar_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample_en <= 1'b0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_result    <= '0;
        end else begin
            r_sample_en <= (w_nxt == TRACK);
            r_busy      <= (w_nxt != IDLE);
            r_overrun   <= w_load && r_valid && !result_ready;
            if (w_load) begin
                r_result <= w_sar_nxt;
            end
            if (!enable) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
            end else if (r_valid && result_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign sample_en    = r_sample_en;
    assign busy         = r_busy;
    assign result_valid = r_valid;
    assign overrun      = r_overrun;
    assign result       = r_result;

endmodule

// File: tb/tb_sar_controller.sv
// Directed bench for sar_controller at RES_BITS=12.
// Expected codes are hand-computed offset-binary values.
module tb_sar_controller;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        start;
    logic        cont;
    logic [3:0]  track_cycles;
    logic        sample_en;
    logic [15:0] hold_p;
    logic [15:0] hold_n;
    logic [11:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;
    logic        overrun;

    int n_vec;
    int n_bad;

    sar_controller #(
        .RES_BITS(12)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .start       (start),
        .cont        (cont),
        .track_cycles(track_cycles),
        .sample_en   (sample_en),
        .hold_p      (hold_p),
        .hold_n      (hold_n),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (busy && c < 60) begin
            tick();
            c++;
        end
        chk(tag, busy, 0);
    endtask

    // lat counts in cycles where the cycle after the start edge is 1
    task automatic single(input logic [15:0] p, input logic [15:0] n,
                          input logic [3:0] trk, input logic [11:0] exp,
                          input string tag);
        int lat;
        int se;
        bit got;
        hold_p       = p;
        hold_n       = n;
        track_cycles = trk;
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        se  = 0;
        got = 1'b0;
        while (!got && lat <= 40) begin
            se += int'(sample_en);
            if (result_valid) got = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        chk({tag, "_valid"}, got, 1);
        chk({tag, "_code"}, result, exp);
        chk({tag, "_lat"}, lat, 16);
        chk({tag, "_se"}, se, 1);
        tick();
        tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t[3];
        int k;
        int run;
        int maxrun;
        int ov;
        int sev;
        int c;
        int drops;
        bit got;

        n_vec        = 0;
        n_bad        = 0;
        reset_n      = 1'b0;
        enable       = 1'b0;
        start        = 1'b0;
        cont         = 1'b0;
        track_cycles = 4'd1;
        hold_p       = 16'h0;
        hold_n       = 16'h0;
        result_ready = 1'b1;

        #12;
        chk("rst_se", sample_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_ovr", overrun, 0);
        @(negedge clk);
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();

        single(16'h9000, 16'h7000, 4'd1, 12'h900, "basic");
        single(16'h4321, 16'h4321, 4'd0, 12'h800, "mid");
        single(16'hFFFF, 16'h0000, 4'd1, 12'hFFF, "top");
        single(16'h0000, 16'hFFFF, 4'd1, 12'h000, "bot");

        // continuous, consumer always ready
        hold_p       = 16'h9000;
        hold_n       = 16'h7000;
        track_cycles = 4'd4;
        result_ready = 1'b1;
        @(negedge clk);
        cont   = 1'b1;
        k      = 0;
        run    = 0;
        maxrun = 0;
        ov     = 0;
        sev    = 0;
        for (int i = 1; i <= 100 && k < 3; i++) begin
            tick();
            if (overrun) ov++;
            if (result_valid) begin
                run++;
                if (run > maxrun) maxrun = run;
                t[k] = i;
                if (sample_en) sev++;
                k++;
            end else begin
                run = 0;
            end
        end
        @(negedge clk);
        cont = 1'b0;
        chk("cont_count", k, 3);
        chk("cont_per1", t[1] - t[0], 18);
        chk("cont_per2", t[2] - t[1], 18);
        chk("cont_pulse", maxrun, 1);
        chk("cont_ovr", ov, 0);
        chk("cont_se_at_v", sev, 3);
        chk("cont_code", result, 12'h900);
        wait_idle("cont_idle");
        tick();

        // continuous, consumer stalled
        track_cycles = 4'd1;
        result_ready = 1'b0;
        @(negedge clk);
        cont = 1'b1;
        c    = 0;
        while (!result_valid && c < 40) begin
            tick();
            c++;
        end
        chk("ovr_first_v", result_valid, 1);
        chk("ovr_first", result, 12'h900);
        hold_p = 16'hFFFF;
        hold_n = 16'h0000;
        drops  = 0;
        got    = 1'b0;
        c      = 0;
        while (!got && c < 40) begin
            tick();
            c++;
            if (!result_valid) drops++;
            if (overrun) got = 1'b1;
        end
        chk("ovr_seen", got, 1);
        chk("ovr_keepv", drops, 0);
        chk("ovr_code", result, 12'hFFF);
        tick();
        chk("ovr_width", overrun, 0);
        chk("ovr_hold", result, 12'hFFF);
        @(negedge clk);
        cont         = 1'b0;
        result_ready = 1'b1;
        tick();
        chk("ovr_accept", result_valid, 0);
        wait_idle("ovr_idle");
        tick();

        // enable dropped in CONVERT
        hold_p       = 16'h0000;
        hold_n       = 16'hFFFF;
        track_cycles = 4'd1;
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("en_busy_pre", busy, 1);
        @(negedge clk);
        enable = 1'b0;
        tick();
        chk("en_busy", busy, 0);
        chk("en_se", sample_en, 0);
        chk("en_valid", result_valid, 0);
        chk("en_result", result, 12'hFFF);
        @(negedge clk);
        enable = 1'b1;
        tick();
        single(16'h1234, 16'h0234, 4'd1, 12'h880, "reen");

        // start while busy must not queue a second conversion
        hold_p = 16'h9000;
        hold_n = 16'h7000;
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (result_valid) c++;
        end
        chk("busy_start_n", c, 1);
        chk("busy_start_code", result, 12'h900);

        // async reset mid TRACK
        track_cycles = 4'd8;
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("ar_se_pre", sample_en, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_se", sample_en, 0);
        chk("ar_busy", busy, 0);
        chk("ar_result", result, 0);
        chk("ar_valid", result_valid, 0);
        chk("ar_ovr", overrun, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sar_controller.md
# sar_controller

Successive-approximation conversion sequencer sitting directly downstream of the sample & hold stage. Drives the S/H `sample_en` strobe for a programmable track window, waits for the held differential value to settle, and resolves it MSB-first against a modelled SAR DAC/comparator. Emits one offset-binary code per conversion over a valid/ready handshake toward the digital back-end, in single-shot or continuous mode.

## Interface
- `RES_BITS`, default 12: result resolution; legal range 8..16.
- `clk`  in  1  system clock, shared with the S/H.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  block enable; tie to the same enable as the S/H.
- `start`  in  1  single-conversion trigger, level-sampled in IDLE.
- `cont`  in  1  continuous mode: re-arm automatically after each conversion.
- `track_cycles`  in  4  track window length in clocks; 0 is treated as 1.
- `sample_en`  out  1  to S/H `sample_en`.
- `hold_p`  in  16  from S/H `vout_p`.
- `hold_n`  in  16  from S/H `vout_n`.
- `result`  out  RES_BITS  conversion code, offset binary.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer accepts.
- `busy`  out  1  high in any state other than IDLE.
- `overrun`  out  1  one-cycle pulse when an unaccepted result is overwritten.

## Operation
- Reset values: `sample_en`=0, `result`=0, `result_valid`=0, `busy`=0, `overrun`=0; state=IDLE.
- IDLE: if `start` or `cont` is high, go to TRACK. Otherwise stay.
- TRACK: `sample_en`=1 for max(`track_cycles`,1) cycles, then go to SETTLE.
- SETTLE: 2 cycles with `sample_en`=0. This covers the S/H's two-register latency, so `hold_*` is stable when the first comparison is made. Then go to CONVERT.
- CONVERT: RES_BITS cycles, bit index i runs from RES_BITS-1 down to 0, one bit per cycle.
  - trial = sar_reg with bit i set.
  - keep bit i if trial <= u_s, otherwise clear it.
- Comparator model, all unsigned arithmetic:
  - u = {1'b0,hold_p} − {1'b0,hold_n} + 17'h10000 (17 bits, no overflow).
  - u_s = u[16:17−RES_BITS].
  - The final sar_reg equals u_s exactly.
- After the last bit: load `result`, set `result_valid`. Next state is TRACK if `cont` is high, else IDLE.
- Handshake: a transfer occurs on any cycle where `result_valid` && `result_ready`.
  - On transfer, `result_valid` clears the next cycle unless a new result loads on the same edge, in which case it stays high with the new code.
  - `result` is stable while `result_valid` is high and unaccepted.
- Overrun: a new result loads while `result_valid` is high and `result_ready` is low.
  - `result` is overwritten with the newest code.
  - `overrun` pulses for 1 cycle.
- `start` is ignored while `busy`. Clearing `cont` mid-conversion finishes the current conversion, then the block returns to IDLE.
- `enable` low has synchronous effect on the next edge: state goes to IDLE, `sample_en`, `busy`, `result_valid` and `overrun` go to 0, and `sar_reg` is cleared. `result` keeps its value.
- Asynchronous reset mid-conversion aborts immediately to the reset values.

## Timing
- `start` sampled high at edge k (in IDLE):
  - `sample_en` is high during cycles k+1 .. k+T, where T = max(`track_cycles`,1).
  - SETTLE occupies cycles k+T+1 and k+T+2.
  - CONVERT occupies cycles k+T+3 .. k+T+2+RES_BITS.
  - `result_valid` rises at k+T+3+RES_BITS.
- Latency from start to valid is T+RES_BITS+3 cycles, which is 16 for T=1, RES_BITS=12.
- Continuous mode: conversion period T+RES_BITS+2 cycles. `sample_en` rises in the same cycle `result_valid` rises.
- `busy` is high from k+1 through the last CONVERT cycle.
- All outputs are registered.

## Structure
- Shared package `adc_pkg`:
  - state enum `sar_state_t`: IDLE, TRACK, SETTLE, CONVERT.
  - constant `SAR_SETTLE_CYC` = 2.
  - constants `ADC_IN_W` = 16 and `ADC_U_W` = 17.
- Sub-module `sar_cmp_model` (combinational): computes u_s from `hold_p`/`hold_n` and returns the trial <= u_s decision. It is replaced by the analog comparator interface in silicon.
- Top level holds the FSM, the track/bit counters, `sar_reg` and the output register.

## Test plan
- RES_BITS=12, `track_cycles`=1, `hold_p`=0x9000, `hold_n`=0x7000, `start` pulse -> `result`=0x900, `result_valid` rises exactly 16 cycles after the start edge, `sample_en` high for exactly 1 cycle.
- Edge codes:
  - `hold_p`=`hold_n`=0x4321 -> 0x800.
  - `hold_p`=0xFFFF, `hold_n`=0 -> 0xFFF.
  - `hold_p`=0, `hold_n`=0xFFFF -> 0x000.
- `cont`=1, `track_cycles`=4, `result_ready` held high -> one result every 18 cycles; `result_valid` is a single-cycle pulse; `overrun` never asserts.
- `cont`=1, `result_ready`=0 -> second result overwrites the first, `overrun` pulses 1 cycle, `result_valid` stays high; raising `result_ready` drops `result_valid` the next cycle.
- `enable` dropped in the middle of CONVERT -> next cycle `busy`=0, `sample_en`=0, `result_valid`=0; after re-enable and `start`, the result is correct. A `start` pulse while `busy` is ignored: one result only.
- `reset_n` asserted asynchronously in the middle of TRACK -> all outputs go to their reset values without waiting for a clock edge.
